// File: rtl/traffic_pkg.sv
// Shared light encodings, phase enum, approach indices and default timing
// for the adaptive intersection phase scheduler.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b100;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_t;

    localparam logic [1:0] APPR_A = 2'd0;
    localparam logic [1:0] APPR_B = 2'd1;
    localparam logic [1:0] APPR_C = 2'd2;
    localparam logic [1:0] APPR_D = 2'd3;

    localparam int unsigned DEF_MIN_GREEN    = 8;
    localparam int unsigned DEF_GREEN_STEP   = 4;
    localparam int unsigned DEF_YELLOW_TIME  = 3;
    localparam int unsigned DEF_ALL_RED_TIME = 2;
    localparam int unsigned DEF_AGE_LIMIT    = 3;
    localparam int unsigned DEF_TW           = 5;

    function automatic logic [2:0] light_for(input phase_t ph, input logic sel);
        logic [2:0] l;
        l = RED;
        if (sel) begin
            case (ph)
                PH_GREEN:  l = GREEN;
                PH_YELLOW: l = YELLOW;
                default:   l = RED;
            endcase
        end
        return l;
    endfunction

endpackage

// File: rtl/phase_picker.sv
// Combinational arbiter: picks the next approach to receive green
// (emergency > aged > density > round-robin) and its green length.
module phase_picker
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = DEF_MIN_GREEN,
    parameter int unsigned GREEN_STEP = DEF_GREEN_STEP,
    parameter int unsigned AGE_LIMIT  = DEF_AGE_LIMIT,
    parameter int unsigned TW         = DEF_TW,
    parameter int unsigned AW         = 2
) (
    input  logic [3:0][1:0]    dens,
    input  logic [3:0][AW-1:0] ages,
    input  logic [3:0]         emg_req,
    input  logic [1:0]         last_served,
    output logic [1:0]         winner,
    output logic [TW:0]        green_len
);

    logic       found;
    logic [1:0] idx;
    logic [1:0] best;

    always_comb begin
        winner    = last_served + 2'd1;
        found     = 1'b0;
        idx       = '0;
        best      = '0;
        green_len = '0;

        // Emergency is fixed priority by index, not rotating.
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && emg_req[i]) begin
                winner = 2'(i);
                found  = 1'b1;
            end
        end

        // Search order starts after last_served; i==3 lands on last_served itself.
        for (int unsigned i = 0; i < 4; i++) begin
            idx = last_served + 2'(i + 1);
            if (!found && ages[idx] == AW'(AGE_LIMIT)) begin
                winner = idx;
                found  = 1'b1;
            end
        end

        for (int unsigned i = 0; i < 4; i++) begin
            idx = last_served + 2'(i + 1);
            if (!found && dens[idx] > best) begin
                best   = dens[idx];
                winner = idx;
            end
        end

        green_len = (TW+1)'(MIN_GREEN)
                  + (TW+1)'(dens[winner]) * (TW+1)'(GREEN_STEP);
    end

endmodule

// File: rtl/adaptive_phase_scheduler.sv
// Four-approach phase scheduler: density-weighted green, aging against
// starvation, and emergency preemption, with its own phase timer.
module adaptive_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN    = DEF_MIN_GREEN,
    parameter int unsigned GREEN_STEP   = DEF_GREEN_STEP,
    parameter int unsigned YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int unsigned ALL_RED_TIME = DEF_ALL_RED_TIME,
    parameter int unsigned AGE_LIMIT    = DEF_AGE_LIMIT,
    parameter int unsigned TW           = DEF_TW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    Sa,
    input  logic [1:0]    Sb,
    input  logic [1:0]    Sc,
    input  logic [1:0]    Sd,
    input  logic [3:0]    emg_req,
    output logic [2:0]    Ta,
    output logic [2:0]    Tb,
    output logic [2:0]    Tc,
    output logic [2:0]    Td,
    output logic [3:0]    grant,
    output logic [1:0]    phase,
    output logic [TW-1:0] timer
);

    localparam int unsigned AW = ($clog2(AGE_LIMIT + 1) > 0) ? $clog2(AGE_LIMIT + 1) : 1;

    phase_t              phase_q, phase_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [TW-1:0]       elapsed_q, elapsed_d;
    logic [3:0][AW-1:0]  age_q, age_d;
    logic [1:0]          last_q, last_d;

    logic [3:0][1:0]     dens;
    logic [1:0]          winner;
    logic [TW:0]         green_len;
    logic [3:0]          cur_onehot;
    logic                other_emg;

    assign dens[0] = {1'b0, Sa[0]} + {1'b0, Sa[1]};
    assign dens[1] = {1'b0, Sb[0]} + {1'b0, Sb[1]};
    assign dens[2] = {1'b0, Sc[0]} + {1'b0, Sc[1]};
    assign dens[3] = {1'b0, Sd[0]} + {1'b0, Sd[1]};

    phase_picker #(
        .MIN_GREEN  (MIN_GREEN),
        .GREEN_STEP (GREEN_STEP),
        .AGE_LIMIT  (AGE_LIMIT),
        .TW         (TW),
        .AW         (AW)
    ) u_picker (
        .dens        (dens),
        .ages        (age_q),
        .emg_req     (emg_req),
        .last_served (last_q),
        .winner      (winner),
        .green_len   (green_len)
    );

    // The granted approach is always last_served while green/yellow.
    assign cur_onehot = 4'b0001 << last_q;
    assign other_emg  = |(emg_req & ~cur_onehot);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= PH_ALL_RED;
            timer_q   <= TW'(ALL_RED_TIME - 1);
            elapsed_q <= '0;
            age_q     <= '0;
            last_q    <= APPR_D;
        end else begin
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            elapsed_q <= elapsed_d;
            age_q     <= age_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        timer_d   = timer_q - 1'b1;
        elapsed_d = (elapsed_q == '1) ? elapsed_q : elapsed_q + 1'b1;
        age_d     = age_q;
        last_d    = last_q;

        unique case (phase_q)
            PH_ALL_RED: begin
                if (timer_q == '0) begin
                    phase_d   = PH_GREEN;
                    timer_d   = TW'(green_len - 1'b1);
                    elapsed_d = '0;
                    last_d    = winner;
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (2'(i) == winner || dens[i] == 2'd0)
                            age_d[i] = '0;
                        else if (age_q[i] != AW'(AGE_LIMIT))
                            age_d[i] = age_q[i] + 1'b1;
                    end
                end
            end
            PH_GREEN: begin
                // Preemption for another approach overrides the timer once minimum green is served.
                if (other_emg && elapsed_q >= TW'(MIN_GREEN - 1)) begin
                    phase_d = PH_YELLOW;
                    timer_d = TW'(YELLOW_TIME - 1);
                end else if (timer_q == '0) begin
                    if (emg_req[last_q] && !other_emg) begin
                        timer_d = '0;
                    end else begin
                        phase_d = PH_YELLOW;
                        timer_d = TW'(YELLOW_TIME - 1);
                    end
                end
            end
            PH_YELLOW: begin
                if (timer_q == '0) begin
                    phase_d = PH_ALL_RED;
                    timer_d = TW'(ALL_RED_TIME - 1);
                end
            end
            default: begin
                phase_d = PH_ALL_RED;
                timer_d = TW'(ALL_RED_TIME - 1);
            end
        endcase
    end

    assign grant = (phase_q == PH_ALL_RED) ? 4'b0000 : cur_onehot;
    assign phase = phase_q;
    assign timer = timer_q;

    assign Ta = light_for(phase_q, grant[APPR_A]);
    assign Tb = light_for(phase_q, grant[APPR_B]);
    assign Tc = light_for(phase_q, grant[APPR_C]);
    assign Td = light_for(phase_q, grant[APPR_D]);

endmodule

// File: tb/tb_adaptive_phase_scheduler.sv
// Directed bench for adaptive_phase_scheduler: checks phase, grant, timer
// and all four lights at hand-computed cycles of each scenario.
module tb_adaptive_phase_scheduler;

    logic       clk;
    logic       rst_n;
    logic [1:0] Sa, Sb, Sc, Sd;
    logic [3:0] emg_req;
    logic [2:0] Ta, Tb, Tc, Td;
    logic [3:0] grant;
    logic [1:0] phase;
    logic [4:0] timer;

    int checks = 0;
    int errors = 0;

    adaptive_phase_scheduler #(
        .MIN_GREEN    (8),
        .GREEN_STEP   (4),
        .YELLOW_TIME  (3),
        .ALL_RED_TIME (2),
        .AGE_LIMIT    (3),
        .TW           (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Sa      (Sa),
        .Sb      (Sb),
        .Sc      (Sc),
        .Sd      (Sd),
        .emg_req (emg_req),
        .Ta      (Ta),
        .Tb      (Tb),
        .Tc      (Tc),
        .Td      (Td),
        .grant   (grant),
        .phase   (phase),
        .timer   (timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] lights(input logic [1:0] ph, input logic [3:0] gr);
        logic [11:0] v;
        logic [2:0]  l;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (gr[i] && ph == 2'd1)      l = 3'b100;
            else if (gr[i] && ph == 2'd2) l = 3'b010;
            else                          l = 3'b001;
            v[11 - 3*i -: 3] = l;
        end
        return v;
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Observed/expected packing: {phase, grant, timer, Ta, Tb, Tc, Td}
    task automatic st(input string tag, input logic [1:0] ph, input logic [3:0] gr, input logic [4:0] tm);
        logic [22:0] obs;
        logic [22:0] exp;
        obs = {phase, grant, timer, Ta, Tb, Tc, Td};
        exp = {ph, gr, tm, lights(ph, gr)};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        Sa = 2'b00; Sb = 2'b00; Sc = 2'b00; Sd = 2'b00;
        emg_req = 4'b0000;
        rst_n = 1'b0;
        tick(1);
        st(tag, 2'd0, 4'b0000, 5'd1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        Sa = 2'b00; Sb = 2'b00; Sc = 2'b00; Sd = 2'b00;
        emg_req = 4'b0000;

        // No demand: round robin starting at A; then reset mid-yellow of B.
        do_reset("t1_reset");
        tick(1); st("t1_c1_allred", 2'd0, 4'b0000, 5'd0);
        tick(1); st("t1_c2_A_green", 2'd1, 4'b0001, 5'd7);
        tick(7); st("t1_c9_A_green_end", 2'd1, 4'b0001, 5'd0);
        tick(1); st("t1_c10_A_yellow", 2'd2, 4'b0001, 5'd2);
        tick(2); st("t1_c12_A_yellow_end", 2'd2, 4'b0001, 5'd0);
        tick(1); st("t1_c13_allred", 2'd0, 4'b0000, 5'd1);
        tick(2); st("t1_c15_B_green", 2'd1, 4'b0010, 5'd7);
        tick(8); st("t1_c23_B_yellow", 2'd2, 4'b0010, 5'd2);
        tick(1); st("t1_c24_B_yellow", 2'd2, 4'b0010, 5'd1);
        rst_n = 1'b0;
        tick(1); st("t6_mid_yellow_reset", 2'd0, 4'b0000, 5'd1);
        rst_n = 1'b1;
        tick(2); st("t6_restart_A", 2'd1, 4'b0001, 5'd7);

        // Density 2 on C only: 16-cycle green, re-granted after all-red.
        do_reset("t2_reset");
        Sc = 2'b11;
        tick(2);  st("t2_C_green", 2'd1, 4'b0100, 5'd15);
        tick(15); st("t2_C_green_end", 2'd1, 4'b0100, 5'd0);
        tick(1);  st("t2_C_yellow", 2'd2, 4'b0100, 5'd2);
        tick(3);  st("t2_allred", 2'd0, 4'b0000, 5'd1);
        tick(2);  st("t2_C_regrant", 2'd1, 4'b0100, 5'd15);

        // B outweighs A three times, then aged A is forced; A's age clears.
        do_reset("t3_reset");
        Sa = 2'b01; Sb = 2'b11;
        tick(2);  st("t3_B_grant1", 2'd1, 4'b0010, 5'd15);
        tick(21); st("t3_B_grant2", 2'd1, 4'b0010, 5'd15);
        tick(21); st("t3_B_grant3", 2'd1, 4'b0010, 5'd15);
        tick(21); st("t3_A_aged", 2'd1, 4'b0001, 5'd11);
        tick(17); st("t3_B_after_age_clear", 2'd1, 4'b0010, 5'd15);

        // Emergency for C truncates A's long green, then C holds past its timer.
        do_reset("t4_reset");
        Sa = 2'b11;
        tick(2); st("t4_A_green", 2'd1, 4'b0001, 5'd15);
        tick(3); st("t4_A_elapsed3", 2'd1, 4'b0001, 5'd12);
        emg_req = 4'b0100;
        tick(4); st("t4_A_elapsed7", 2'd1, 4'b0001, 5'd8);
        tick(1); st("t4_A_truncated_yellow", 2'd2, 4'b0001, 5'd2);
        tick(3); st("t4_allred", 2'd0, 4'b0000, 5'd1);
        tick(2); st("t4_C_emg_green", 2'd1, 4'b0100, 5'd7);
        tick(7); st("t4_C_timer0", 2'd1, 4'b0100, 5'd0);
        tick(4); st("t4_C_hold", 2'd1, 4'b0100, 5'd0);
        emg_req = 4'b0000;
        tick(1); st("t4_C_release_yellow", 2'd2, 4'b0100, 5'd2);

        // Two emergencies: lowest index wins, the other follows.
        do_reset("t5_reset");
        emg_req = 4'b1010;
        tick(2); st("t5_B_emg", 2'd1, 4'b0010, 5'd7);
        emg_req = 4'b1000;
        tick(8); st("t5_B_yellow", 2'd2, 4'b0010, 5'd2);
        tick(5); st("t5_D_emg", 2'd1, 4'b1000, 5'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
